// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor with start/busy/done handshake and signed overflow
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d;
  logic            c_q;
  logic [CW-1:0]   cnt_q;
  logic [DIGIT:0]  sum_d;
  logic            ov_d, last_d;
  assign busy = state_q == RUN;
  // one digit of the sum; the new digit enters the result from the top so the last one lands in the MSBs
  always_comb begin
    sum_d  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    r_d    = (r_q >> DIGIT) | (WIDTH'(sum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    ov_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum_d[DIGIT-1] ^ sum_d[DIGIT];
    last_d = cnt_q == CW'(N - 1);
  end
  // control FSM, operand shifters and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      done    <= 1'b0;
      S       <= '0;
      CO      <= 1'b0;
      OV      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= RUN;
          a_q     <= A;
          b_q     <= B ^ {WIDTH{SUB}};
          c_q     <= CI ^ SUB;
          cnt_q   <= '0;
        end
      end else begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        c_q   <= sum_d[DIGIT];
        r_q   <= r_d;
        cnt_q <= cnt_q + CW'(1);
        if (last_d) begin
          state_q <= IDLE;
          done    <= 1'b1;
          S       <= r_d;
          CO      <= sum_d[DIGIT];
          OV      <= ov_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench with arithmetic reference model for serial_addsub
module tb_serial_addsub;
  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, ci = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, co, ov;
  logic [7:0] s;

  logic s3 = 1'b0, ci3 = 1'b0, sub3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic busy3, done3, co3, ov3;
  logic [2:0] so3;

  logic s4 = 1'b0, ci4 = 1'b0, sub4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic busy4, done4, co4, ov4;
  logic [7:0] so4;

  int cyc = 0;
  int compared = 0, mismatched = 0;
  int run_beg = 1, run_end = 0;
  bit mon_en = 0;
  exp_t sb[$];
  exp_t held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .CI(ci), .SUB(sub),
    .busy(busy), .done(done), .S(s), .CO(co), .OV(ov));
  serial_addsub #(.WIDTH(3), .DIGIT(1)) u3 (
    .clk(clk), .rst(rst), .start(s3), .A(a3), .B(b3), .CI(ci3), .SUB(sub3),
    .busy(busy3), .done(done3), .S(so3), .CO(co3), .OV(ov3));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .CI(ci4), .SUB(sub4),
    .busy(busy4), .done(done4), .S(so4), .CO(co4), .OV(ov4));

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic m, input int t);
    exp_t e;
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    r = m ? sx - sy - int'(c) : sx + sy + int'(c);
    e.ov = r > 127 || r < -128;
    e.s = m ? x - y - {7'b0, c} : x + y + {7'b0, c};
    e.co = m ? (int'(x) >= int'(y) + int'(c)) : (int'(x) + int'(y) + int'(c) > 255);
    e.t = t;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m);
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("idle_timeout", 1, 0);
    start = 1'b1; a = x; b = y; ci = c; sub = m;
    sb.push_back(model(x, y, c, m, cyc + 1 + 8));
    run_beg = cyc + 1;
    run_end = cyc + 8;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; ci = $urandom; sub = $urandom;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("drain_timeout", 1, 0);
  endtask

  // monitor: checks busy every cycle, pops the scoreboard on done, otherwise checks output hold
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("busy", {31'b0, busy}, {31'b0, cyc >= run_beg && cyc <= run_end});
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("S", {24'b0, s}, {24'b0, e.s});
          chk("CO", {31'b0, co}, {31'b0, e.co});
          chk("OV", {31'b0, ov}, {31'b0, e.ov});
          chk("done_cycle", cyc, e.t);
          held = e;
        end
      end else begin
        chk("hold", {22'b0, s, co, ov}, {22'b0, held.s, held.co, held.ov});
      end
    end
  end

  initial begin
    exp_t e;
    int c0, k;
    held.s = '0; held.co = 1'b0; held.ov = 1'b0; held.t = 0;
    repeat (3) @(negedge clk);
    mon_en = 1;
    rst = 1'b0;
    @(negedge clk);
    op(8'h05, 8'h03, 1'b0, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    op(8'hFF, 8'h01, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0);
    op(8'h05, 8'h07, 1'b0, 1'b1);
    op(8'h80, 8'h01, 1'b0, 1'b1);
    op(8'h05, 8'h03, 1'b1, 1'b1);
    wait_idle();
    @(negedge clk);
    op(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; ci = 1'b1; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    op(8'h33, 8'h44, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    held.s = '0; held.co = 1'b0; held.ov = 1'b0;
    run_end = 0;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    op(8'hC8, 8'h64, 1'b0, 1'b0);
    op(8'h10, 8'h20, 1'b0, 1'b0);
    wait_idle();
    for (int i = 0; i < 60; i++) begin
      op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_idle();
    chk("queue_empty", sb.size(), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s3 = 1'b1; a3 = 3'(i); b3 = 3'(i); ci3 = 1'b0; sub3 = 1'b0; c0 = cyc;
      @(negedge clk);
      s3 = 1'b0; a3 = 3'($urandom);
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!done3 && k < 20);
      chk("w3_done", {31'b0, done3}, 1);
      chk("w3_latency", cyc, c0 + 1 + 3);
      chk("w3_S", {29'b0, so3}, {29'b0, 3'(2 * i)});
      chk("w3_CO", {31'b0, co3}, {31'b0, i[2]});
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s4 = 1'b1; c0 = cyc;
      if (i == 0) begin a4 = 8'hFF; b4 = 8'h01; ci4 = 1'b0; sub4 = 1'b0; end
      else begin a4 = 8'($urandom); b4 = 8'($urandom); ci4 = 1'($urandom); sub4 = 1'($urandom); end
      e = model(a4, b4, ci4, sub4, c0 + 1 + 2);
      @(negedge clk);
      s4 = 1'b0;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!done4 && k < 20);
      chk("d4_done", {31'b0, done4}, 1);
      chk("d4_latency", cyc, e.t);
      chk("d4_S", {24'b0, so4}, {24'b0, e.s});
      chk("d4_CO", {31'b0, co4}, {31'b0, e.co});
      chk("d4_OV", {31'b0, ov4}, {31'b0, e.ov});
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
